// File: rtl/rect_bounce_ctl_if.sv
// Bus between the frame/mouse sources and the rectangle motion controller.
// The controller uses the slave side: it samples vblnk and the mouse inputs
// and drives the rectangle position and busy flag.
interface rect_bounce_ctl_if;
  logic        vblnk_in;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;

  modport slave (
    input  vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
    output xpos, ypos, busy
  );

  modport master (
    output vblnk_in, mouse_xpos, mouse_ypos, mouse_left,
    input  xpos, ypos, busy
  );
endinterface

// File: rtl/rect_bounce_ctl.sv
// Per-frame rectangle motion controller. It follows the mouse while idle.
// A left click drops the rectangle, which falls under gravity, bounces
// on the floor with 3/4 damping, and stops once a bounce is too weak.
// Motion advances once per frame, on the rising edge of vblnk.
module rect_bounce_ctl #(
  parameter int SCREEN_H = 600,
  parameter int RECT_H   = 64,
  parameter int G        = 1,
  parameter int VMAX     = 32,
  parameter int MIN_V    = 3
) (
  input  logic                pclk,
  input  logic                rst,
  rect_bounce_ctl_if.slave    bus
);

  localparam logic [11:0] FLOOR   = 12'(SCREEN_H - RECT_H);
  localparam logic [12:0] FLOOR13 = 13'(SCREEN_H - RECT_H);
  localparam logic [11:0] G12     = 12'(G);
  localparam logic [12:0] G13     = 13'(G);
  localparam logic [12:0] VMAX13  = 13'(VMAX);
  localparam logic [12:0] MINV13  = 13'(MIN_V);

  typedef enum logic [1:0] {IDLE, FALL, RISE, STOP} state_t;

  state_t      state, state_nxt;
  logic [11:0] xpos_q, xpos_nxt;
  logic [11:0] ypos_q, ypos_nxt;
  logic [11:0] vel, vel_nxt;
  logic        busy_q, busy_nxt;
  logic        vblnk_d, left_d;

  logic        tick, click;
  logic [12:0] sum_v, v_fall, y_fall, b_fall;
  logic [11:0] v_rise;

  assign tick  = bus.vblnk_in & ~vblnk_d;
  assign click = bus.mouse_left & ~left_d;

  assign bus.xpos = xpos_q;
  assign bus.ypos = ypos_q;
  assign bus.busy = busy_q;

  // Arithmetic for the fall and rise steps. Sums are kept 13 bits wide so
  // that nothing can wrap. v_rise is only used when vel > G.
  always_comb begin
    sum_v  = {1'b0, vel} + G13;
    v_fall = (sum_v > VMAX13) ? VMAX13 : sum_v;
    y_fall = {1'b0, ypos_q} + v_fall;
    b_fall = v_fall - (v_fall >> 2);
    v_rise = vel - G12;
  end

  // Next-state and next-output logic. The default is to hold everything.
  always_comb begin
    state_nxt = state;
    xpos_nxt  = xpos_q;
    ypos_nxt  = ypos_q;
    vel_nxt   = vel;
    unique case (state)
      IDLE: begin
        // Track the pointer every cycle. A click wins over a coincident tick,
        // so that tick is consumed without any motion.
        xpos_nxt = bus.mouse_xpos;
        ypos_nxt = (bus.mouse_ypos > FLOOR) ? FLOOR : bus.mouse_ypos;
        vel_nxt  = '0;
        if (click) state_nxt = FALL;
      end
      FALL: begin
        if (tick) begin
          if (y_fall >= FLOOR13) begin
            ypos_nxt = FLOOR;
            if (b_fall < MINV13) begin
              vel_nxt   = '0;
              state_nxt = STOP;
            end else begin
              vel_nxt   = b_fall[11:0];
              state_nxt = RISE;
            end
          end else begin
            ypos_nxt = y_fall[11:0];
            vel_nxt  = v_fall[11:0];
          end
        end
      end
      RISE: begin
        if (tick) begin
          if (vel <= G12) begin
            // Apex reached: start falling again from rest.
            vel_nxt   = '0;
            state_nxt = FALL;
          end else if (ypos_q < v_rise) begin
            // Would pass the top of the screen: pin to 0 and fall.
            ypos_nxt  = '0;
            vel_nxt   = '0;
            state_nxt = FALL;
          end else begin
            ypos_nxt = ypos_q - v_rise;
            vel_nxt  = v_rise;
          end
        end
      end
      STOP: begin
        if (click) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == FALL) || (state_nxt == RISE);
  end

  // State, motion registers and edge-detect delays.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vel     <= '0;
      busy_q  <= 1'b0;
      vblnk_d <= 1'b0;
      left_d  <= 1'b0;
    end else begin
      state   <= state_nxt;
      xpos_q  <= xpos_nxt;
      ypos_q  <= ypos_nxt;
      vel     <= vel_nxt;
      busy_q  <= busy_nxt;
      vblnk_d <= bus.vblnk_in;
      left_d  <= bus.mouse_left;
    end
  end

endmodule

// File: tb/tb_rect_bounce_ctl.sv
// Bench for rect_bounce_ctl. It drives table-driven steps, where each step
// sets the mouse, an optional one-cycle click and an optional one-cycle vblnk
// pulse. A scoreboard queue holds the expected outputs. Hand-written
// sequences cover async reset and a long vblnk pulse.
module tb_rect_bounce_ctl;
  logic pclk = 1'b0;
  logic rst  = 1'b1;

  rect_bounce_ctl_if bus();

  rect_bounce_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [11:0] mx, my;
    logic        click, tick;
    logic [11:0] ex, ey;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [11:0] x, y;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [11:0] act,
                     input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int idx, input exp_t e);
    chk({nm, ".xpos"}, idx, bus.xpos, e.x);
    chk({nm, ".ypos"}, idx, bus.ypos, e.y);
    chk({nm, ".busy"}, idx, {11'd0, bus.busy}, {11'd0, e.busy});
  endtask

  // Called at a negedge. The step drives its inputs, and the expectation for
  // the following edge goes on the queue. The outputs are compared at the
  // next negedge. Click and vblnk are then dropped for one more cycle.
  task automatic run_step(input string nm, input int idx, input vec_t v);
    exp_t e;
    bus.mouse_xpos = v.mx;
    bus.mouse_ypos = v.my;
    bus.mouse_left = v.click;
    bus.vblnk_in   = v.tick;
    sb.push_back('{x: v.ex, y: v.ey, busy: v.eb});
    @(negedge pclk);
    e = sb.pop_front();
    chk_out(nm, idx, e);
    bus.mouse_left = 1'b0;
    bus.vblnk_in   = 1'b0;
    @(negedge pclk);
  endtask

  function automatic vec_t mk(input int mx, input int my, input bit c,
                              input bit t, input int ex, input int ey,
                              input bit eb);
    vec_t v;
    v.mx = 12'(mx); v.my = 12'(my); v.click = c; v.tick = t;
    v.ex = 12'(ex); v.ey = 12'(ey); v.eb = eb;
    return v;
  endfunction

  initial begin
    exp_t e;
    int   fall_y[8];
    int   rise_y[6];
    fall_y = '{506, 510, 515, 521, 528, 536, 0, 0};
    rise_y = '{531, 527, 524, 522, 521, 521};

    // Table A: fall, bounce and rise from (100,500). During the fall, the
    // mouse moves and a click arrives; both must be ignored.
    tab_a.push_back(mk(100, 500, 0, 0, 100, 500, 0));
    tab_a.push_back(mk(100, 500, 1, 0, 100, 500, 1));
    tab_a.push_back(mk(200, 300, 0, 1, 100, 501, 1));
    tab_a.push_back(mk(200, 300, 1, 1, 100, 503, 1));
    tab_a.push_back(mk(200, 300, 0, 0, 100, 503, 1));
    for (int i = 0; i < 6; i++)
      tab_a.push_back(mk(200, 300, 0, 1, 100, fall_y[i], 1));
    for (int i = 0; i < 6; i++)
      tab_a.push_back(mk(200, 300, 0, 1, 100, rise_y[i], 1));
    tab_a.push_back(mk(200, 300, 0, 1, 100, 522, 1));

    // Table B: the rectangle comes to a stop, then the clamp, then a click
    // that coincides with a tick.
    tab_b.push_back(mk(10, 534, 0, 0, 10, 534, 0));
    tab_b.push_back(mk(10, 534, 1, 0, 10, 534, 1));
    tab_b.push_back(mk(99, 534, 0, 1, 10, 535, 1));
    tab_b.push_back(mk(99, 534, 0, 1, 10, 536, 0));
    tab_b.push_back(mk(99, 400, 0, 1, 10, 536, 0));
    tab_b.push_back(mk(99, 400, 1, 1, 10, 536, 0));
    tab_b.push_back(mk(99, 400, 0, 0, 99, 400, 0));
    tab_b.push_back(mk(88, 700, 0, 0, 88, 536, 0));
    tab_b.push_back(mk(88, 100, 0, 0, 88, 100, 0));
    tab_b.push_back(mk(88, 100, 1, 1, 88, 100, 1));
    tab_b.push_back(mk(55, 100, 0, 0, 88, 100, 1));
    tab_b.push_back(mk(55, 100, 0, 1, 88, 101, 1));
    tab_b.push_back(mk(55, 100, 0, 1, 88, 103, 1));

    bus.vblnk_in = 1'b0; bus.mouse_left = 1'b0;
    bus.mouse_xpos = 12'd321; bus.mouse_ypos = 12'd222;
    repeat (2) @(negedge pclk);
    chk_out("reset", 0, '{x: 12'd0, y: 12'd0, busy: 1'b0});
    rst = 1'b0;
    @(negedge pclk);

    foreach (tab_a[i]) run_step("tab_a", i, tab_a[i]);

    // vblnk held high for several cycles produces exactly one step:
    // FALL with vel=1 moves 2 pixels, from 522 to 524.
    bus.vblnk_in = 1'b1;
    @(negedge pclk);
    chk("long_vblnk.first", 0, bus.ypos, 12'd524);
    repeat (3) @(negedge pclk);
    chk("long_vblnk.hold", 0, bus.ypos, 12'd524);
    bus.vblnk_in = 1'b0;
    @(negedge pclk);

    // Reset mid-fall with ypos = 300.
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    run_step("mid", 0, mk(50, 290, 0, 0, 50, 290, 0));
    run_step("mid", 1, mk(50, 290, 1, 0, 50, 290, 1));
    run_step("mid", 2, mk(0, 0, 0, 1, 50, 291, 1));
    run_step("mid", 3, mk(0, 0, 0, 1, 50, 293, 1));
    run_step("mid", 4, mk(0, 0, 0, 1, 50, 296, 1));
    run_step("mid", 5, mk(0, 0, 0, 1, 50, 300, 1));
    bus.mouse_xpos = 12'd77; bus.mouse_ypos = 12'd123;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, '{x: 12'd0, y: 12'd0, busy: 1'b0});
    @(negedge pclk);
    rst = 1'b0;
    sb.push_back('{x: 12'd77, y: 12'd123, busy: 1'b0});
    @(negedge pclk);
    e = sb.pop_front();
    chk_out("after_rst", 0, e);

    foreach (tab_b[i]) run_step("tab_b", i, tab_b[i]);

    chk("sb_empty", 0, 12'(sb.size()), 12'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
